// File: rtl/jk_excitation_counter.sv
// Modulo-MOD up/down counter. It keeps a shadow copy of the external JK bank state and
// drives the minimal J/K excitation to that bank. Define JKC_FEEDBACK_CHECK_EN to compare the bank feedback.
module jk_excitation_counter #(
    parameter int W   = 4,
    parameter int MOD = 10
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         en,
    input  logic         up,
    input  logic         load,
    input  logic [W-1:0] din,
    input  logic [W-1:0] q_fb,
    output logic [W-1:0] j,
    output logic [W-1:0] k,
    output logic [W-1:0] q,
    output logic         tc,
    output logic         err
);

    localparam logic [W:0] MOD_X  = (W+1)'(MOD);
    localparam logic [W:0] LAST_X = (W+1)'(MOD - 1);

    logic [W-1:0] q_q, q_d;
    logic         tc_q, tc_d;
    logic [W:0]   q_x, din_x, nxt_x;
    logic         wrap;
    logic         unused_nxt_msb;

    // The extra bit keeps MOD = 2^W representable, and it keeps the clamp compare exact.
    always_comb begin
        q_x   = {1'b0, q_q};
        din_x = {1'b0, din};
        nxt_x = q_x;
        wrap  = 1'b0;
        if (load) begin
            nxt_x = (din_x < MOD_X) ? din_x : LAST_X;
        end else if (en && up) begin
            if (q_x == LAST_X) begin
                nxt_x = '0;
                wrap  = 1'b1;
            end else begin
                nxt_x = q_x + 1'b1;
            end
        end else if (en) begin
            if (q_x == '0) begin
                nxt_x = LAST_X;
                wrap  = 1'b1;
            end else begin
                nxt_x = q_x - 1'b1;
            end
        end
    end

    assign q_d            = nxt_x[W-1:0];
    assign tc_d           = wrap;
    assign unused_nxt_msb = nxt_x[W];

    // When a bit keeps its value, its don't-care resolves to 0. So J and K are never both 1.
    assign j = clr ? '0 : (q_d & ~q_q);
    assign k = clr ? '0 : (q_q & ~q_d);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            q_q  <= '0;
            tc_q <= 1'b0;
        end else begin
            q_q  <= q_d;
            tc_q <= tc_d;
        end
    end

    assign q  = q_q;
    assign tc = tc_q;

`ifdef JKC_FEEDBACK_CHECK_EN
    logic skip_q, skip_d;
    logic err_q, err_d;

    // The first edge after clr is skipped, so the external bank can leave its own clear.
    always_comb begin
        skip_d = 1'b0;
        err_d  = err_q | (~skip_q & (q_fb != q_q));
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            skip_q <= 1'b1;
            err_q  <= 1'b0;
        end else begin
            skip_q <= skip_d;
            err_q  <= err_d;
        end
    end

    assign err = err_q;
`else
    logic unused_q_fb;
    assign unused_q_fb = ^q_fb;
    assign err         = 1'b0;
`endif

endmodule

// File: tb/tb_jk_excitation_counter.sv
// Directed bench for jk_excitation_counter (W=4, MOD=10). The expected values are worked out by hand.
module tb_jk_excitation_counter;

    logic       clk = 1'b0;
    logic       clr, en, up, load;
    logic [3:0] din, j, k, q, q_fb, fb_mask;
    logic       tc, err;
    int         total = 0;
    int         bad   = 0;
    logic       err_exp;

    always #5 clk = ~clk;

    // The modelled bank follows q. fb_mask lets the bench corrupt selected feedback bits.
    assign q_fb = q ^ fb_mask;

    jk_excitation_counter #(.W(4), .MOD(10)) dut (
        .clk(clk), .clr(clr), .en(en), .up(up), .load(load), .din(din),
        .q_fb(q_fb), .j(j), .k(k), .q(q), .tc(tc), .err(err)
    );

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        clr = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; din = '0; fb_mask = '0;
`ifdef JKC_FEEDBACK_CHECK_EN
        err_exp = 1'b1;
`else
        err_exp = 1'b0;
`endif
        #3;
        chk("rst_q", 16'(q), 16'd0);
        chk("rst_tc", 16'(tc), 16'd0);
        chk("rst_err", 16'(err), 16'd0);
        tick();
        clr = 1'b0;

        load = 1'b1; din = 4'd7;
        tick();
        chk("load7_q", 16'(q), 16'd7);
        load = 1'b0; en = 1'b1; up = 1'b1;
        #1;
        chk("j_7to8", 16'(j), 16'b1000);
        chk("k_7to8", 16'(k), 16'b0111);
        tick();
        chk("cnt8_q", 16'(q), 16'd8);
        #2 clr = 1'b1;
        #1;
        chk("async_clr_q", 16'(q), 16'd0);
        chk("async_clr_j", 16'(j), 16'd0);
        chk("async_clr_k", 16'(k), 16'd0);
        chk("async_clr_tc", 16'(tc), 16'd0);
        clr = 1'b0;
        tick();
        chk("after_clr_q", 16'(q), 16'd1);

        // Up wrap: 8 -> 9 -> 0
        en = 1'b0; load = 1'b1; din = 4'd8;
        tick();
        load = 1'b0; en = 1'b1; up = 1'b1;
        tick();
        chk("up9_q", 16'(q), 16'd9);
        chk("up9_tc", 16'(tc), 16'd0);
        chk("j_at9", 16'(j), 16'b0000);
        chk("k_at9", 16'(k), 16'b1001);
        tick();
        chk("upwrap_q", 16'(q), 16'd0);
        chk("upwrap_tc", 16'(tc), 16'd1);
        tick();
        chk("up1_q", 16'(q), 16'd1);
        chk("up1_tc", 16'(tc), 16'd0);

        // Down wrap: 0 -> 9 -> 8
        load = 1'b1; din = 4'd0;
        tick();
        chk("load0_q", 16'(q), 16'd0);
        chk("load0_tc", 16'(tc), 16'd0);
        load = 1'b0; up = 1'b0;
        #1;
        chk("j_at0", 16'(j), 16'b1001);
        chk("k_at0", 16'(k), 16'b0000);
        tick();
        chk("dnwrap_q", 16'(q), 16'd9);
        chk("dnwrap_tc", 16'(tc), 16'd1);
        tick();
        chk("dn8_q", 16'(q), 16'd8);
        chk("dn8_tc", 16'(tc), 16'd0);

        // Load priority, clamp, and a load that lands on a wrap endpoint
        load = 1'b1; din = 4'd12; up = 1'b1;
        tick();
        chk("clamp_q", 16'(q), 16'd9);
        chk("clamp_tc", 16'(tc), 16'd0);
        din = 4'd0;
        tick();
        chk("load_end_q", 16'(q), 16'd0);
        chk("load_end_tc", 16'(tc), 16'd0);
        din = 4'd3;
        tick();
        chk("load3_q", 16'(q), 16'd3);

        load = 1'b0; en = 1'b0;
        #1;
        chk("hold_j", 16'(j), 16'd0);
        chk("hold_k", 16'(k), 16'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_q", 16'(q), 16'd3);
        end

        // Feedback: 20 clean cycles, then one corrupted cycle
        en = 1'b1; up = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        chk("fb_clean_q", 16'(q), 16'd3);
        chk("fb_clean_err", 16'(err), 16'd0);
        fb_mask = 4'b0100;
        tick();
        fb_mask = '0;
        chk("fb_bad_err", 16'(err), 16'(err_exp));
        tick();
        tick();
        chk("fb_sticky_err", 16'(err), 16'(err_exp));
        clr = 1'b1;
        #1;
        chk("fb_clr_err", 16'(err), 16'd0);
        clr = 1'b0;
        fb_mask = 4'b0100;
        tick();
        fb_mask = '0;
        chk("fb_skip_err", 16'(err), 16'd0);
        chk("fb_skip_q", 16'(q), 16'd1);
        tick();
        chk("fb_after_err", 16'(err), 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/jk_excitation_counter.md
Name: jk_excitation_counter

Overview:
- Synchronous modulo-N up/down counter that drives a bank of external JK flip-flops.
- Keeps a shadow copy of the present state and computes the next state each cycle.
- Outputs the minimal J/K excitation per bit so the external bank reaches that next state on the same clock edge.
- Sits directly upstream of the JK flip-flop cells; optionally checks their fed-back outputs against the shadow state.

Parameters:
- W, 4, counter/bank width in bits (2..16)
- MOD, 10, count modulus; legal range 2..2^W; count sequence is 0..MOD-1

Ports:
- clk  input  1  rising-edge clock, shared with the external JK bank
- clr  input  1  reset, asynchronous and active-high
- en  input  1  count enable
- up  input  1  direction: 1 = increment, 0 = decrement
- load  input  1  synchronous load request
- din  input  W  load value
- q_fb  input  W  Q outputs fed back from the external JK bank
- j  output  W  J excitation to the external bank
- k  output  W  K excitation to the external bank
- q  output  W  shadow present state (registered)
- tc  output  1  terminal-count pulse (registered)
- err  output  1  sticky feedback-mismatch flag (registered)

Behaviour:
- Reset (clr=1, asynchronous): q=0, tc=0, err=0. While clr is high, j and k are forced to all-zero.
- Next-state selection, in priority order:
  1. load=1: nxt = din if din < MOD, else MOD-1 (clamp). en and up are ignored.
  2. en=1, up=1: nxt = q+1; when q = MOD-1, nxt = 0 (wrap).
  3. en=1, up=0: nxt = q-1; when q = 0, nxt = MOD-1 (wrap).
  4. Otherwise: nxt = q (hold).
- Excitation (combinational from q and the controls, per bit i):
  - j[i] = nxt[i] & ~q[i]
  - k[i] = q[i] & ~nxt[i]
  - The don't-care terms resolve to 0, so j and k are never both 1 and the toggle code is never issued.
  - On hold, j = k = 0.
- State update: q <= nxt on every rising clk edge. The external bank and q change on the same edge, so latency is zero cycles relative to the bank.
- tc: registered, high for exactly one cycle after an edge on which a wrap occurred (up-wrap MOD-1 -> 0 or down-wrap 0 -> MOD-1, both due to en). A load never asserts tc, even when the loaded value equals a wrap endpoint.
- Arithmetic: modulo arithmetic is performed in W+1 bits internally. q never holds a value >= MOD, including after reset and after load.
- MOD = 2^W: wrap occurs naturally at all-ones; behaviour is identical to the general case.
- clr asserted mid-count: state, tc and err clear immediately, without waiting for clk. Counting resumes from 0 on the first edge after clr falls.

Optional Feature:
- Macro: JKC_FEEDBACK_CHECK_EN
- Defined:
  - On each rising edge with clr=0, compare q_fb against q. The comparison is made on the same edge, before q updates, i.e. both sample the state of the previous cycle.
  - Any mismatch sets err=1. err stays 1 until clr.
  - q_fb is ignored in the cycle immediately after clr deasserts, to allow the external bank to leave its own clear.
- Not defined: err is tied to 0 and q_fb is unused; no compare logic is synthesised.

Test Plan:
- Reset: clr=1 during count 7 -> q=0, tc=0, err=0, j=k=0 immediately. After release with en=1, up=1: q=1 on the first edge.
- Up wrap: MOD=10, en=1, up=1 from 8 -> q 9 then 0; tc=1 for exactly the cycle after 9 -> 0.
  - Excitation at q=9 (1001b): j=0000b, k=1001b.
- Down wrap: load 0, then en=1, up=0 -> q=9 on the next edge, tc pulses once.
  - Excitation at q=0: j=1001b, k=0000b.
- Load priority and clamp:
  - load=1, din=12, en=1, up=1 -> q=9, tc=0.
  - load=1, din=3 -> q=3.
  - Hold (en=0, load=0) -> j=k=0 and q stable for 5 cycles.
- Feedback check (macro defined):
  - q_fb mirrors q for 20 cycles -> err=0.
  - Force q_fb bit 2 wrong for one cycle -> err=1 on the next edge and stays 1 until clr.
- Build without the macro: same mismatch stimulus -> err stays 0.
